// File: rtl/multicycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_pkg
// Shared definitions for the RV32I multi-cycle sequencer:
//   - state_t       : main FSM state encoding
//   - trap_cause_t  : trap cause codes reported on trap_cause
//   - OP_*          : RV32I base opcode constants (IR[6:0])
//   - is_legal_opcode(): opcode legality check used in DECODE
// -----------------------------------------------------------------------------
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LUI, OP_AUIPC, OP_OP, OP_IMM, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_if
// Memory request/ready handshake between the sequencer and the memory port.
//   mem_req      : access request, held until mem_ready
//   mem_we       : 1 = store access (valid while mem_req)
//   mem_addr_sel : 0 = PC (fetch), 1 = ALU result (load/store)
//   mem_ready    : memory completes the current access this cycle
// modport master : sequencer side; modport slave : memory side.
// -----------------------------------------------------------------------------
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer_perf_counter.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_perf_counter
// Free-running wrap-around event counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   en    : count enable, one increment per enabled cycle
//   cnt   : current count, wraps 2^CNT_W-1 -> 0
// -----------------------------------------------------------------------------
module multicycle_sequencer_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// Main multi-cycle FSM of the RV32I core: FETCH -> DECODE -> EXECUTE ->
// (MEM) -> (WB). Owns the memory handshake, the bus timeout, traps and the
// cycle/instret performance counters.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   run            : fetch enable, sampled in FETCH before a request issues
//   opcode         : IR[6:0] of the latched instruction
//   branch_taken   : branch comparator result, valid in EXECUTE
//   mem            : memory handshake (master modport)
//   ir_we, alu_out_we, rf_we, pc_we, pc_sel : datapath strobes
//   retire         : one-cycle pulse per completed instruction
//   trap, trap_cause : sticky stop flag and its cause
//   cycle_cnt, instret_cnt : wrap-around performance counters
// -----------------------------------------------------------------------------
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [6:0]             opcode,
  input  logic                   branch_taken,
  multicycle_sequencer_if.master mem,
  output logic                   ir_we,
  output logic                   alu_out_we,
  output logic                   rf_we,
  output logic                   pc_we,
  output logic                   pc_sel,
  output logic                   retire,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       instret_cnt
);

  // The wait counter never needs to hold more than MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            state_q, state_d;
  trap_cause_t       cause_q, cause_d;
  logic              active_q;
  logic              fetch_pend_q;
  logic [WAIT_W-1:0] wait_q;

  logic mem_req_c, mem_we_c, mem_addr_sel_c;
  logic wait_hit;

  logic is_branch, is_load, is_store, is_jump;
  assign is_branch = (opcode == OP_BRANCH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

  // Request has been outstanding for MEM_TIMEOUT cycles without completion.
  assign wait_hit = mem_req_c && !mem.mem_ready &&
                    (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // State register. active_q holds off fetching for the first cycle after
  // reset release so no request can appear while rst_n is low or glitch out
  // on the release edge. fetch_pend_q keeps an issued fetch alive when run
  // drops before mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      cause_q      <= CAUSE_NONE;
      active_q     <= 1'b0;
      fetch_pend_q <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      active_q     <= 1'b1;
      fetch_pend_q <= (state_q == ST_FETCH) && mem_req_c &&
                      !mem.mem_ready && !wait_hit;
      if (mem_req_c && !mem.mem_ready && !wait_hit) begin
        wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_FETCH: begin
        if (wait_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (mem_req_c && mem.mem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        if (is_branch)                 state_d = ST_FETCH;
        else if (is_load || is_store)  state_d = ST_MEM;
        else                           state_d = ST_WB;
      end
      ST_MEM: begin
        if (wait_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (mem.mem_ready) begin
          state_d = is_store ? ST_FETCH : ST_WB;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output logic: Moore on state_q, except strobes qualified by mem_ready.
  always_comb begin
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we          = 1'b0;
    alu_out_we     = 1'b0;
    rf_we          = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 1'b0;
    retire         = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem_req_c = active_q && (run || fetch_pend_q);
        ir_we     = mem_req_c && mem.mem_ready;
      end
      ST_DECODE: ;
      ST_EXECUTE: begin
        alu_out_we = 1'b1;
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = is_store;
        if (is_store && mem.mem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        pc_sel = is_jump;
        retire = 1'b1;
      end
      ST_TRAP: ;
      default: ;
    endcase
  end

  assign mem.mem_req      = mem_req_c;
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;
  assign trap             = (state_q == ST_TRAP);
  assign trap_cause       = cause_q;

  multicycle_sequencer_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (cycle_cnt)
  );

  multicycle_sequencer_perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .cnt   (instret_cnt)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed bench: each instruction's expected per-cycle strobe pattern is
// pushed to a scoreboard queue, then popped and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int TO = 5;
  localparam int CW = 16;

  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_IMM    = 7'b0010011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BAD    = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          ir_we, alu_out_we, rf_we, pc_we, pc_sel, retire, trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  multicycle_sequencer_if mif ();

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem          (mif.master),
    .ir_we        (ir_we),
    .alu_out_we   (alu_out_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .retire       (retire),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  // {trap, cause[1:0], req, we, addr_sel, ir_we, alu_out_we, rf_we, pc_we, pc_sel, retire}
  logic [11:0] obs_vec;
  assign obs_vec = {trap, trap_cause, mif.mem_req, mif.mem_we, mif.mem_addr_sel,
                    ir_we, alu_out_we, rf_we, pc_we, pc_sel & pc_we, retire};

  typedef struct packed {
    logic        run;
    logic        rdy;
    logic [11:0] vec;
  } step_t;

  step_t         sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cyc;
  logic [CW-1:0] exp_ret;

  // Expected cycle count: one per clock edge while out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_cyc <= '0;
    else        exp_cyc <= exp_cyc + CW'(1);
  end

  function automatic logic [11:0] mk(input bit req, we, asel, irw, alu, rf, pcw, pcs, ret);
    return {3'b000, req, we, asel, irw, alu, rf, pcw, pcs, ret};
  endfunction

  function automatic logic [11:0] trapv(input logic [1:0] cause);
    return {1'b1, cause, 9'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input bit r, input bit rdy, input logic [11:0] v);
    step_t s;
    s.run = r;
    s.rdy = rdy;
    s.vec = v;
    sb.push_back(s);
  endtask

  // Expected per-cycle behaviour of one instruction, from its fetch onwards.
  task automatic push_instr(input logic [6:0] op, input bit taken, input int fwait,
                            input int mwait, input bit drop_run);
    bit br, ld, st, jmp, legal;
    int k;
    br    = (op == T_BRANCH);
    ld    = (op == T_LOAD);
    st    = (op == T_STORE);
    jmp   = (op == T_JAL) || (op == T_JALR);
    legal = (op != T_BAD);
    k = 0;
    for (int i = 0; i < fwait; i++) begin
      push(!(drop_run && k > 0), 1'b0, mk(1,0,0,0,0,0,0,0,0));
      k++;
    end
    push(!(drop_run && k > 0), 1'b1, mk(1,0,0,1,0,0,0,0,0));
    push(!drop_run, 1'b1, mk(0,0,0,0,0,0,0,0,0));
    if (legal) begin
      if (br) push(!drop_run, 1'b0, mk(0,0,0,0,1,0,1,taken,1));
      else    push(!drop_run, 1'b0, mk(0,0,0,0,1,0,0,0,0));
      if (ld || st) begin
        for (int i = 0; i < mwait; i++) push(!drop_run, 1'b0, mk(1,st,1,0,0,0,0,0,0));
        push(!drop_run, 1'b1, mk(1,st,1,0,0,0,st,0,st));
      end
      if (!br && !st) push(!drop_run, 1'b0, mk(0,0,0,0,0,1,1,jmp,1));
      if (legal) exp_ret = exp_ret + CW'(1);
    end
  endtask

  task automatic run_sb(input string tag);
    step_t s;
    int n;
    n = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      run = s.run;
      mif.mem_ready = s.rdy;
      #1;
      check($sformatf("%s_c%0d", tag, n), 32'(obs_vec), 32'(s.vec));
      n++;
    end
  endtask

  task automatic check_cnts(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_instret"}, 32'(instret_cnt), 32'(exp_ret));
    check({tag, "_cycle"}, 32'(cycle_cnt), 32'(exp_cyc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b1;
    mif.mem_ready = 1'b1;
    exp_ret = '0;
    #1;
    check("in_reset_out", 32'(obs_vec), 32'(0));
    check("in_reset_cyc", 32'(cycle_cnt), 32'(0));
    check("in_reset_ret", 32'(instret_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_release", 32'(obs_vec), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    opcode = T_IMM;
    branch_taken = 1'b0;
    mif.mem_ready = 1'b0;
    exp_ret = '0;
    repeat (2) @(negedge clk);
    do_reset();

    opcode = T_IMM;   push_instr(T_IMM, 0, 0, 0, 0);    run_sb("addi");   check_cnts("addi");
    opcode = T_BRANCH; branch_taken = 1'b1;
    push_instr(T_BRANCH, 1, 0, 0, 0); run_sb("beq_t");  check_cnts("beq_t");
    branch_taken = 1'b0;
    push_instr(T_BRANCH, 0, 0, 0, 0); run_sb("beq_nt"); check_cnts("beq_nt");
    opcode = T_LOAD;  push_instr(T_LOAD, 0, 1, 3, 0);   run_sb("lw");     check_cnts("lw");
    opcode = T_STORE; push_instr(T_STORE, 0, 0, 1, 0);  run_sb("sw");     check_cnts("sw");
    opcode = T_JAL;   push_instr(T_JAL, 0, 0, 0, 0);    run_sb("jal");    check_cnts("jal");
    opcode = T_JALR;  push_instr(T_JALR, 0, 2, 0, 0);   run_sb("jalr");   check_cnts("jalr");
    opcode = T_LUI;   push_instr(T_LUI, 0, 0, 0, 0);    run_sb("lui");    check_cnts("lui");

    // run drops while the fetch is outstanding: instruction still completes.
    opcode = T_OP;    push_instr(T_OP, 0, 2, 0, 1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0));
    run_sb("droprun"); check_cnts("droprun");

    // Illegal opcode traps after DECODE; counters keep counting cycles only.
    opcode = T_BAD;   push_instr(T_BAD, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, trapv(2'b01));
    run_sb("illegal"); check_cnts("illegal");

    // Fetch timeout.
    do_reset();
    for (int i = 0; i < TO; i++) push(1'b1, 1'b0, mk(1,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 2; i++) push(1'b1, 1'b1, trapv(2'b10));
    run_sb("timeout"); check_cnts("timeout");

    // Asynchronous reset in the middle of an outstanding fetch.
    do_reset();
    for (int i = 0; i < 2; i++) push(1'b1, 1'b0, mk(1,0,0,0,0,0,0,0,0));
    run_sb("midfetch");
    #2;
    rst_n = 1'b0;
    #1;
    check("midfetch_rst_out", 32'(obs_vec), 32'(0));
    check("midfetch_rst_cyc", 32'(cycle_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
